// File: rtl/micromind_pkg.sv
// micromind_pkg
//   Parameters and helpers shared by the micromind blocks.
//   MM_WIDTH    : timestamp / shared counter width
//   EDGE_*      : edge_sel encodings used by the capture block
//   edge_hit()  : qualifies a synchronized transition against an edge_sel code
package micromind_pkg;

  localparam int MM_WIDTH = 8;

  typedef logic [1:0] edge_sel_t;

  localparam edge_sel_t EDGE_RISE = 2'b00;
  localparam edge_sel_t EDGE_FALL = 2'b01;
  localparam edge_sel_t EDGE_BOTH = 2'b10;
  localparam edge_sel_t EDGE_OFF  = 2'b11;

  function automatic logic edge_hit(edge_sel_t sel, logic cur, logic prev);
    case (sel)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/micromind_capture_fifo.sv
// micromind_capture_fifo
//   Synchronous show-ahead timestamp FIFO with occupancy output.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     wr_en, wr_data  : push request and data
//     rd_en           : pop request (ignored while empty)
//     rd_data         : oldest entry, 0 while empty
//     valid           : FIFO non-empty
//     full            : FIFO holds DEPTH entries
//     level           : occupancy 0..DEPTH
//   A push while full is accepted only if a pop happens on the same edge.
module micromind_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Storage is not reset, so the read port is forced to 0 while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign valid   = !empty;
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/micromind_capture.sv
// micromind_capture
//   Synchronizes an asynchronous event line, detects the selected edge and
//   stores the upstream counter value at the detection edge into a
//   show-ahead timestamp FIFO.
//   Parameters: WIDTH (timestamp width, = shared counter width),
//               DEPTH (FIFO entries, power of 2, >= 2),
//               SYNC_STAGES (evt_in synchronizer flops, >= 2).
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     count       : free-running upstream counter
//     evt_in      : asynchronous event line
//     edge_sel    : 00 rise, 01 fall, 10 both, 11 disabled
//     ts_data     : oldest timestamp (show-ahead), ts_valid: FIFO non-empty
//     ts_ready    : consumer accepts ts_data
//     level       : FIFO occupancy
//     overflow    : sticky, an event was dropped on a full FIFO
//     ovf_clr     : synchronous clear of overflow (a same-edge drop wins)
//     drop_cnt    : saturating dropped-event count, present only when
//                   MICROMIND_CAPTURE_DROP_CNT_EN is defined
module micromind_capture
  import micromind_pkg::*;
#(
  parameter int WIDTH       = MM_WIDTH,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             count,
  input  logic                         evt_in,
  input  logic [1:0]                   edge_sel,
  output logic [WIDTH-1:0]             ts_data,
  output logic                         ts_valid,
  input  logic                         ts_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
`ifdef MICROMIND_CAPTURE_DROP_CNT_EN
  output logic [7:0]                   drop_cnt,
`endif
  input  logic                         ovf_clr
);

  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INHIBIT_LOAD = IW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   evt_dly;
  logic                   evt_sync;
  logic [IW-1:0]          inhibit_cnt;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   drop;

  assign evt_sync = sync_q[SYNC_STAGES-1];

  // The delayed copy follows the synchronizer every cycle, independent of
  // edge_sel, so reprogramming edge_sel never fabricates an edge.
  // inhibit_cnt masks the edge that the synchronizer filling up after reset
  // would otherwise show when evt_in is already high at release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      evt_dly     <= 1'b0;
      inhibit_cnt <= INHIBIT_LOAD;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], evt_in};
      evt_dly <= evt_sync;
      if (inhibit_cnt != '0) inhibit_cnt <= inhibit_cnt - IW'(1);
    end
  end

  assign push = (inhibit_cnt == '0) && edge_hit(edge_sel, evt_sync, evt_dly);
  assign pop  = ts_valid && ts_ready;
  assign drop = push && full && !pop;

  micromind_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (count),
    .rd_en   (ts_ready),
    .rd_data (ts_data),
    .valid   (ts_valid),
    .full    (full),
    .level   (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef MICROMIND_CAPTURE_DROP_CNT_EN
  // A drop coinciding with ovf_clr restarts the count at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop) begin
      if (ovf_clr)               drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt <= 8'd0;
    end
  end
`endif

endmodule
